pulse_generator_mc: RTL
=======================

PULSE_GENERATOR_MC -- requirements
Module: pulse_generator_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent pulse channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8: width of the pulse-length and gap-length counters.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of the trigger synchroniser (2..3).
REQ-004 SHALL have port clk  input  1: single clock for all logic.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port trig  input  NUM_CH: asynchronous trigger inputs, one per channel.
REQ-007 SHALL have port en  input  NUM_CH: per-channel enable; while low, edges are ignored and the channel is forced to IDLE.
REQ-008 SHALL have port width  input  CNT_W: pulse length in clk cycles, shared by all channels.
REQ-009 SHALL have port gap  input  CNT_W: minimum low time after a pulse, in clk cycles, shared.
REQ-010 SHALL have port mode  input  1: 0 = ignore retrigger, 1 = extend on retrigger.
REQ-011 SHALL have port clr  input  1: synchronous clear of all overrun flags.
REQ-012 SHALL have port pulse  output  NUM_CH: generated pulses, active high, registered.
REQ-013 SHALL have port busy  output  NUM_CH: high while a channel is in PULSE or GAP.
REQ-014 SHALL have port done  output  NUM_CH: one-cycle strobe in the last cycle of each pulse.
REQ-015 SHALL have port overrun  output  NUM_CH: sticky flag marking a trigger edge dropped by the channel.

Function
REQ-016 SHALL synchronise each trig bit through SYNC_STAGES flops, then detect rising edges by comparing against one additional registered copy.
REQ-017 SHALL run one FSM per channel with states IDLE, PULSE and GAP.
REQ-018 SHALL, in IDLE with en=1, on a detected edge with width>0: load the counter with width, enter PULSE, and drive pulse=1 from the next cycle.
REQ-019 SHALL ignore an edge when width=0: no pulse, no done strobe, no overrun.
REQ-020 SHALL sample width only at pulse start (and at extend reloads); changes to width during PULSE do not affect the running pulse.
REQ-021 SHALL keep pulse high for exactly width cycles, counting down to 1, and assert done in the cycle the counter equals 1.
REQ-022 SHALL, on leaving PULSE, enter GAP loaded with gap when gap>0, otherwise enter IDLE directly.
REQ-023 SHALL hold pulse low in GAP for exactly gap cycles, then return to IDLE.
REQ-024 SHALL, for an edge in PULSE with mode=1, reload the counter with width with no low glitch on pulse and no done strobe for the truncated segment.
REQ-025 SHALL, for an edge in PULSE with mode=0, or any edge in GAP, drop the edge and set overrun.
REQ-026 SHALL accept an edge in the same cycle GAP expires (counter=1), treating it as IDLE, so back-to-back pulses are possible.
REQ-027 SHALL, when en falls mid-operation, return the channel to IDLE next cycle and clear pulse/busy, without issuing done.
REQ-028 SHALL give clr priority over a simultaneous overrun set, so overrun reads 0 after that cycle.
REQ-029 SHALL keep total latency, trig rise to pulse rise, at exactly SYNC_STAGES+2 cycles.
REQ-030 SHALL keep channels fully independent; one channel's activity never affects another.

Reset
REQ-031 SHALL, while rst_n=0, immediately force: all FSMs to IDLE, counters to 0, synchroniser and edge flops to 0, and pulse, busy, done, overrun to 0.
REQ-032 SHALL not detect the trigger's current level as an edge after reset release; an edge detects only on a 0-to-1 transition seen after release.

Structure
REQ-033 SHALL place the channel state enum (IDLE/PULSE/GAP) and the mode encodings in the shared package pulse_gen_pkg.
REQ-034 SHALL implement one channel (synchroniser, edge detect, FSM, counter) as sub-module pulse_channel, instantiated NUM_CH times via generate.

Verification
REQ-035 SHALL cover: SYNC_STAGES=2, width=5, gap=0, a single trig rise on ch0 -> pulse[0] rises 4 cycles later, stays high 5 cycles, done[0] coincides with its 5th cycle.
REQ-036 SHALL cover: mode=1, width=4, second edge 2 cycles into the pulse -> pulse continuous for 6 cycles, exactly one done strobe.
REQ-037 SHALL cover: mode=0, width=4, gap=3, edges at pulse cycle 2 and at gap cycle 1 -> pulse 4 cycles, overrun[ch]=1, and clr next cycle -> overrun=0.
REQ-038 SHALL cover: width=0 with repeated edges -> pulse, done and overrun stay 0.
REQ-039 SHALL cover: rst_n asserted mid-pulse, with trig held high through release -> outputs 0 immediately and no pulse after release until trig falls and rises again.
REQ-040 SHALL cover: simultaneous edges on all 4 channels, with en[2]=0 -> channels 0, 1, 3 pulse identically and channel 2 stays idle.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared types for the multi-channel pulse generator: channel state and
// retrigger mode encodings.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } ch_state_t;

    localparam logic MODE_IGNORE = 1'b0;
    localparam logic MODE_EXTEND = 1'b1;

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: trigger synchroniser, rising-edge detect, and the
// IDLE/PULSE/GAP sequencer with its shared down-counter.
//
// state    | meaning
// ST_IDLE  | waiting for a trigger edge
// ST_PULSE | pulse high, counter holds remaining high cycles
// ST_GAP   | pulse low hold-off, counter holds remaining gap cycles
module pulse_channel
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             en,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic             mode,
    input  logic             clr,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   vld_q;
    logic                   edge_q;
    ch_state_t              state;
    logic [CNT_W-1:0]       cnt_q;

    // vld_q gates detection until prev_q holds a sample taken after reset,
    // so a trigger already high at release is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            vld_q  <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trig};
            prev_q <= sync_q[SYNC_STAGES-1];
            vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
            edge_q <= vld_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    logic evt, last, extend, drop;

    assign evt    = edge_q & en & (width != '0);
    assign last   = (cnt_q == CNT_W'(1));
    assign extend = evt & (mode == MODE_EXTEND) & (state == ST_PULSE);
    assign drop   = evt & (((state == ST_PULSE) & (mode == MODE_IGNORE)) |
                           ((state == ST_GAP) & ~last));

    assign busy = (state != ST_IDLE);
    assign done = en & (state == ST_PULSE) & last & ~extend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt_q   <= '0;
            pulse   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= clr ? 1'b0 : (overrun | drop);
            if (!en) begin
                state <= ST_IDLE;
                cnt_q <= '0;
                pulse <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (evt) begin
                            state <= ST_PULSE;
                            cnt_q <= width;
                            pulse <= 1'b1;
                        end
                    end
                    ST_PULSE: begin
                        if (extend) begin
                            cnt_q <= width;
                        end else if (last) begin
                            pulse <= 1'b0;
                            if (gap != '0) begin
                                state <= ST_GAP;
                                cnt_q <= gap;
                            end else begin
                                state <= ST_IDLE;
                                cnt_q <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_GAP: begin
                        // An edge in the final gap cycle starts the next pulse directly.
                        if (last) begin
                            if (evt) begin
                                state <= ST_PULSE;
                                cnt_q <= width;
                                pulse <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                cnt_q <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt_q <= '0;
                        pulse <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/pulse_generator_mc.sv
// Multi-channel pulse generator: NUM_CH independent channels sharing the
// width/gap/mode configuration and the overrun clear.
module pulse_generator_mc
    import pulse_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] trig,
    input  logic [NUM_CH-1:0] en,
    input  logic [CNT_W-1:0]  width,
    input  logic [CNT_W-1:0]  gap,
    input  logic              mode,
    input  logic              clr,
    output logic [NUM_CH-1:0] pulse,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] overrun
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_channel #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .trig   (trig[i]),
            .en     (en[i]),
            .width  (width),
            .gap    (gap),
            .mode   (mode),
            .clr    (clr),
            .pulse  (pulse[i]),
            .busy   (busy[i]),
            .done   (done[i]),
            .overrun(overrun[i])
        );
    end

endmodule
